// File: rtl/fetch_request_unit.sv
// fetch_request_unit: credit-based I-cache fetch request generator with redirect/drain handling.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   redirect_valid/redirect_pc branch redirect (coincides with the instruction-queue flush)
//   q_pop                      instruction queue dequeued one entry this cycle
//   req_valid/req_pc/req_ready I-cache fetch request handshake
//   rsp_valid/rsp_data/rsp_pc  in-order I-cache response
//   out_valid/out_data/out_pc  instruction-queue write port
// Optional: define FETCH_PERF_CNT_EN to add perf_issued, perf_discarded, perf_hold_cycles.
module fetch_request_unit #(
    parameter int          QUEUE_DEPTH     = 8,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        q_pop,
    output logic        req_valid,
    output logic [31:0] req_pc,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic [31:0] rsp_pc,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_discarded,
    output logic [31:0] perf_hold_cycles
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic [CW-1:0] credits, credits_n;
    logic [OW-1:0] outstanding, outstanding_n, discard, discard_n;
    logic          hs, rsp_ok, drop;

    assign req_valid     = (state == FETCH) & ~rst;
    assign req_pc        = pc;
    assign hs            = req_valid & req_ready;
    // A response with nothing in flight is spurious and ignored entirely.
    assign rsp_ok        = rsp_valid & (outstanding != '0);
    assign drop          = rsp_ok & (discard != '0);
    assign out_valid     = rsp_ok & (discard == '0) & ~rst;
    assign out_data      = rsp_data;
    assign out_pc        = rsp_pc;
    assign outstanding_n = outstanding + OW'(hs) - OW'(rsp_ok);

    always_comb begin
        pc_n      = hs ? pc + 32'd4 : pc;
        credits_n = credits - CW'(hs) + CW'(q_pop) + CW'(drop);
        discard_n = discard - OW'(drop);
        state_n   = state;
        case (state)
            FETCH:   state_n = (credits_n == '0 || outstanding_n == OW'(MAX_OUTSTANDING)) ? HOLD : FETCH;
            HOLD:    state_n = (credits_n != '0 && outstanding_n < OW'(MAX_OUTSTANDING)) ? FETCH : HOLD;
            DRAIN:   state_n = (discard == '0) ? FETCH : DRAIN;
            default: state_n = FETCH;
        endcase
        // Everything still in flight after this cycle belongs to the wrong path;
        // the queue is flushed, so credits restart from full minus those requests.
        if (redirect_valid) begin
            pc_n      = redirect_pc;
            discard_n = outstanding_n;
            credits_n = CW'(QUEUE_DEPTH) - CW'(outstanding_n);
            state_n   = (outstanding_n != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            credits     <= CW'(QUEUE_DEPTH);
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            credits     <= credits_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued      <= '0;
            perf_discarded   <= '0;
            perf_hold_cycles <= '0;
        end else begin
            if (hs && perf_issued != '1)
                perf_issued <= perf_issued + 32'd1;
            if (drop && perf_discarded != '1)
                perf_discarded <= perf_discarded + 32'd1;
            if (state == HOLD && perf_hold_cycles != '1)
                perf_hold_cycles <= perf_hold_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_request_unit.sv
// tb_fetch_request_unit: directed self-checking bench with an in-order I-cache model acting as scoreboard.
module tb_fetch_request_unit;
    logic        clk, rst, redirect_valid, q_pop, req_valid, req_ready;
    logic        rsp_valid, out_valid;
    logic [31:0] redirect_pc, req_pc, rsp_data, rsp_pc, out_data, out_pc;

    fetch_request_unit dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .q_pop(q_pop), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_pc(rsp_pc),
        .out_valid(out_valid), .out_data(out_data), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          fwd;
    } ent_t;

    ent_t        sb[$];
    int          n_cmp = 0, n_err = 0, occ = 0, n_hs = 0, n_drop = 0;
    bit          rsp_en = 0, auto_pop = 0, pop_once = 0, first_pending = 0;
    logic [31:0] exp_pc = 32'h0, last_pc = 32'h0, first_pc = 32'h0;

    function automatic logic [31:0] data_of(input logic [31:0] p);
        return {p[15:0], ~p[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        ent_t e;
        bit   hs, had_rsp;
        had_rsp   = rsp_en && sb.size() > 0;
        rsp_valid = had_rsp;
        rsp_pc    = had_rsp ? sb[0].pc : 32'h0;
        rsp_data  = had_rsp ? data_of(sb[0].pc) : 32'h0;
        q_pop     = (auto_pop && occ > 0) || pop_once;
        @(negedge clk);
        if (req_valid) chk("req_pc", req_pc, exp_pc);
        if (had_rsp) begin
            e = sb.pop_front();
            chk("out_valid", {31'b0, out_valid}, {31'b0, e.fwd});
            if (e.fwd && out_valid) begin
                chk("out_pc", out_pc, e.pc);
                chk("out_data", out_data, data_of(e.pc));
            end
            if (!e.fwd) n_drop++;
        end else
            chk("out_idle", {31'b0, out_valid}, 32'h0);
        hs = req_valid && req_ready;
        if (hs) begin
            n_hs++;
            last_pc = req_pc;
            if (first_pending) begin
                first_pc      = req_pc;
                first_pending = 0;
            end
        end
        if (redirect_valid) begin
            foreach (sb[i]) sb[i].fwd = 0;
            occ = 0;
        end else
            occ = occ + int'(out_valid) - int'(q_pop);
        if (hs) sb.push_back('{pc: exp_pc, fwd: !redirect_valid});
        exp_pc = redirect_valid ? redirect_pc : hs ? exp_pc + 32'd4 : exp_pc;
        @(posedge clk);
        #1;
        redirect_valid = 0;
        pop_once       = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_req_pc", req_pc, 32'h0);
        chk("rst_credits", 32'(dut.credits), 32'd8);
        chk("rst_discard", 32'(dut.discard), 32'd0);
        rsp_valid = 0; q_pop = 0; redirect_valid = 0; pop_once = 0;
        sb.delete();
        occ = 0; n_hs = 0; n_drop = 0; exp_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1; redirect_valid = 0; redirect_pc = 0; q_pop = 0; req_ready = 0;
        rsp_valid = 0; rsp_data = 0; rsp_pc = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming with 1-cycle cache, queue drained continuously
        req_ready = 1; rsp_en = 1; auto_pop = 1;
        repeat (12) cyc();
        chk("stream_hs", n_hs, 12);

        // No pops: exactly QUEUE_DEPTH requests, then hold; one pop frees one more
        do_reset();
        req_ready = 1; rsp_en = 1; auto_pop = 0;
        repeat (20) cyc();
        chk("fill_hs", n_hs, 8);
        chk("hold_req_valid", {31'b0, req_valid}, 32'h0);
        pop_once = 1;
        cyc();
        repeat (8) cyc();
        chk("pop_hs", n_hs, 9);
        chk("pop_pc", last_pc, 32'h20);

        // Redirect with 3 outstanding
        do_reset();
        req_ready = 1; rsp_en = 0; auto_pop = 1;
        repeat (3) cyc();
        req_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
        cyc();
        chk("drain_req_valid", {31'b0, req_valid}, 32'h0);
        req_ready = 1; rsp_en = 1; n_drop = 0; first_pending = 1;
        repeat (10) cyc();
        chk("drain_drops", n_drop, 3);
        chk("drain_first_pc", first_pc, 32'h100);
        req_ready = 0;
        repeat (6) cyc();
        chk("idle_credits", 32'(dut.credits), 32'd8);

        // Stalled cache: request held stable for 5 cycles
        do_reset();
        req_ready = 0; rsp_en = 1; auto_pop = 1;
        repeat (5) begin
            cyc();
            chk("stall_valid", {31'b0, req_valid}, 32'h1);
            chk("stall_pc", req_pc, 32'h0);
        end
        chk("stall_hs", n_hs, 0);
        req_ready = 1;
        cyc();
        chk("stall_release_hs", n_hs, 1);
        chk("stall_release_pc", last_pc, 32'h0);

        // Redirect coinciding with handshake at 0x8 and a q_pop
        do_reset();
        req_ready = 1; rsp_en = 1; auto_pop = 0;
        repeat (2) cyc();
        rsp_en = 0; redirect_valid = 1; redirect_pc = 32'h200; pop_once = 1;
        cyc();
        chk("coin_hs_pc", last_pc, 32'h8);
        chk("coin_discard", 32'(dut.discard), 32'd2);
        chk("coin_credits", 32'(dut.credits), 32'd6);
        rsp_en = 1; auto_pop = 1; first_pending = 1;
        repeat (8) cyc();
        chk("coin_first_pc", first_pc, 32'h200);

        // Asynchronous reset in the middle of a drain
        do_reset();
        req_ready = 1; rsp_en = 0; auto_pop = 1;
        repeat (2) cyc();
        req_ready = 0; redirect_valid = 1; redirect_pc = 32'h300;
        cyc();
        rsp_en = 1;
        cyc();
        rsp_valid = 1; rsp_pc = 32'h4; rsp_data = data_of(32'h4);
        do_reset();
        req_ready = 1; rsp_en = 1;
        repeat (4) cyc();
        chk("restart_hs", n_hs, 4);
        chk("restart_pc", last_pc, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_request_unit.md
FETCH_REQUEST_UNIT -- requirements
Module: fetch_request_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 8: instruction-queue slots; power of two, at least 2.
REQ-002 Parameter MAX_OUTSTANDING, default 4: maximum I-cache requests in flight, at least 1.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 redirect_valid / redirect_pc  in  1 / 32  branch-resolution redirect; same cycle as the queue flush.
REQ-007 q_pop  in  1  queue dequeued one entry this cycle (valid and not stalled).
REQ-008 req_valid / req_pc  out  1 / 32  I-cache fetch request.
REQ-009 req_ready  in  1  I-cache accepts the request when req_valid and req_ready are both high.
REQ-010 rsp_valid / rsp_data / rsp_pc  in  1 / 32 / 32  I-cache response; returned in request order.
REQ-011 out_valid / out_data / out_pc  out  1 / 32 / 32  write port into the instruction queue.

Function
REQ-012 The block SHALL hold pc, credits, outstanding, discard and a 2-bit state; width of credits = $clog2(QUEUE_DEPTH+1); width of outstanding and discard = $clog2(MAX_OUTSTANDING+1).
REQ-013 The credits register SHALL track free queue slots minus in-flight requests: decrement on handshake, increment on q_pop and on each discarded response, net zero when events coincide.
REQ-014 States SHALL be FETCH, HOLD and DRAIN.
REQ-015 req_valid SHALL be high only in FETCH, with req_pc = pc.
REQ-016 A handshake SHALL advance pc by 4.
REQ-017 FETCH SHALL go to HOLD when, after this cycle's updates, credits == 0 or outstanding == MAX_OUTSTANDING.
REQ-018 HOLD SHALL return to FETCH when credits > 0 and outstanding < MAX_OUTSTANDING.
REQ-019 On redirect_valid (any state), pc SHALL load redirect_pc.
REQ-020 On redirect_valid, discard SHALL load the post-cycle outstanding count, including any handshake in that cycle.
REQ-021 On redirect_valid, credits SHALL load QUEUE_DEPTH minus the new discard value, and q_pop in that cycle SHALL be ignored.
REQ-022 On redirect_valid, state SHALL become DRAIN if the new discard > 0, else FETCH.
REQ-023 Redirect SHALL take priority over all other events in the same cycle.
REQ-024 A response with discard > 0 SHALL be dropped (out_valid low), decrementing discard and outstanding and returning one credit.
REQ-025 A response with discard == 0 SHALL be forwarded combinationally (out_valid = rsp_valid, out_data = rsp_data, out_pc = rsp_pc) and SHALL decrement outstanding.
REQ-026 DRAIN SHALL go to FETCH in the cycle after discard reaches 0; a redirect during DRAIN reloads discard as above.
REQ-027 The queue SHALL never overflow: out_valid high implies a credit was reserved.
REQ-028 A response arriving with outstanding == 0 SHALL be ignored.
REQ-029 A response received in the same cycle as redirect_valid SHALL be counted as already retired, not discarded.

Reset
REQ-030 While rst is high: pc = RESET_PC, credits = QUEUE_DEPTH, outstanding = 0, discard = 0, state = FETCH, req_valid = 0, out_valid = 0.
REQ-031 Reset asserted mid-operation SHALL abandon in-flight requests immediately; the I-cache and queue are reset in the same domain.

Configuration
REQ-032 With FETCH_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_issued, perf_discarded and perf_hold_cycles, which count handshakes, dropped responses and cycles in HOLD, reset to 0 and saturate.
REQ-033 Without FETCH_PERF_CNT_EN, those ports and counters SHALL NOT exist.

Verification
REQ-034 After reset with req_ready=1 and a 1-cycle latency cache: req_pc sequence 0,4,8,...; out_pc matches with 1-cycle lag.
REQ-035 No q_pop, QUEUE_DEPTH=8: exactly 8 handshakes, then HOLD with req_valid=0; one q_pop -> exactly one further request at pc 0x20.
REQ-036 Redirect to 0x100 with 3 outstanding: next 3 responses dropped (out_valid=0), DRAIN, then first request at req_pc 0x100; credits reach 8 once the queue is idle.
REQ-037 req_ready held low 5 cycles: req_valid and req_pc 0x0 held stable and pc unchanged; handshake on the 6th cycle.
REQ-038 Redirect coinciding with a handshake at 0x8 and a q_pop: discard includes the 0x8 request, q_pop ignored, req_pc = redirect_pc after drain.
REQ-039 rst pulsed asynchronously mid-DRAIN: all outputs go to reset values without waiting for a clock edge; fetch restarts at RESET_PC.
